// File: rtl/mdu_arbiter.sv
// Two-requester arbiter/sequencer in front of a shared multiply/divide unit.
// Define MDU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module mdu_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned P_DATA_MSB = WIDTH - 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0_valid,
  input  logic             i_req1_valid,
  output logic             o_req0_ready,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req0_rs1,
  input  logic [WIDTH-1:0] i_req0_rs2,
  input  logic [WIDTH-1:0] i_req1_rs1,
  input  logic [WIDTH-1:0] i_req1_rs2,
  input  logic [2:0]       i_req0_op,
  input  logic [2:0]       i_req1_op,
  output logic             o_rsp0_valid,
  output logic             o_rsp1_valid,
  input  logic             i_rsp0_ready,
  input  logic             i_rsp1_ready,
  output logic [WIDTH-1:0] o_rsp_rd,
  output logic [WIDTH-1:0] o_mdu_rs1,
  output logic [WIDTH-1:0] o_mdu_rs2,
  output logic [2:0]       o_mdu_op,
  output logic             o_mdu_valid,
  input  logic             i_mdu_ready,
  input  logic [WIDTH-1:0] i_mdu_rd,
  output logic             o_busy
);

  localparam int unsigned OP_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                gnt_q;
  logic                win_c;
  logic                accept_c;
  logic                capture_c;
  logic [P_DATA_MSB:0] rs1_q, rs2_q, rsp_q;
  logic [OP_W-1:0]     op_q;

`ifndef MDU_ARB_FIXED_PRIO_EN
  logic                last_q;
`endif

  // Winner index: 0 or 1; only meaningful when at least one request is valid.
  always_comb begin
`ifdef MDU_ARB_FIXED_PRIO_EN
    win_c = !i_req0_valid;
`else
    win_c = (i_req0_valid && i_req1_valid) ? !last_q : !i_req0_valid;
`endif
  end

  always_comb begin
    state_d      = state_q;
    accept_c     = 1'b0;
    capture_c    = 1'b0;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    o_rsp0_valid = 1'b0;
    o_rsp1_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_req0_valid || i_req1_valid) begin
          accept_c     = 1'b1;
          o_req0_ready = !win_c;
          o_req1_ready = win_c;
          state_d      = S_BUSY;
        end
      end
      S_BUSY: begin
        if (i_mdu_ready) begin
          capture_c = 1'b1;
          state_d   = S_RESP;
        end
      end
      // MDU ready is ignored here: its trailing done strobe lands in this state.
      S_RESP: begin
        o_rsp0_valid = !gnt_q;
        o_rsp1_valid = gnt_q;
        if (gnt_q ? i_rsp1_ready : i_rsp0_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      op_q    <= '0;
      rsp_q   <= '0;
`ifndef MDU_ARB_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (accept_c) begin
        gnt_q  <= win_c;
        rs1_q  <= win_c ? i_req1_rs1 : i_req0_rs1;
        rs2_q  <= win_c ? i_req1_rs2 : i_req0_rs2;
        op_q   <= win_c ? i_req1_op  : i_req0_op;
`ifndef MDU_ARB_FIXED_PRIO_EN
        last_q <= win_c;
`endif
      end
      if (capture_c) begin
        rsp_q <= i_mdu_rd;
      end
    end
  end

  assign o_mdu_valid = (state_q == S_BUSY);
  assign o_busy      = (state_q != S_IDLE);
  assign o_mdu_rs1   = rs1_q;
  assign o_mdu_rs2   = rs2_q;
  assign o_mdu_op    = op_q;
  assign o_rsp_rd    = rsp_q;

endmodule

// File: tb/tb_mdu_arbiter.sv
// Scoreboard bench for mdu_arbiter with a behavioural MDU (mul done strobe incl. trailing strobe, multi-cycle div).
module tb_mdu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_rs1 = '0, req0_rs2 = '0, req1_rs1 = '0, req1_rs2 = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] rsp_rd;
  logic [31:0] mdu_rs1, mdu_rs2, mdu_rd;
  logic [2:0]  mdu_op;
  logic        mdu_valid, mdu_ready, busy;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  op;
  } req_t;

  req_t        q0[$], q1[$];
  int          exp_gnt[$];
  logic [31:0] exp_rsp0[$], exp_rsp1[$];

  always #5 clk = ~clk;

  mdu_arbiter #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(req0_valid), .i_req1_valid(req1_valid),
    .o_req0_ready(req0_ready), .o_req1_ready(req1_ready),
    .i_req0_rs1(req0_rs1), .i_req0_rs2(req0_rs2),
    .i_req1_rs1(req1_rs1), .i_req1_rs2(req1_rs2),
    .i_req0_op(req0_op), .i_req1_op(req1_op),
    .o_rsp0_valid(rsp0_valid), .o_rsp1_valid(rsp1_valid),
    .i_rsp0_ready(rsp0_ready), .i_rsp1_ready(rsp1_ready),
    .o_rsp_rd(rsp_rd),
    .o_mdu_rs1(mdu_rs1), .o_mdu_rs2(mdu_rs2), .o_mdu_op(mdu_op),
    .o_mdu_valid(mdu_valid), .i_mdu_ready(mdu_ready), .i_mdu_rd(mdu_rd),
    .o_busy(busy)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endfunction

  // Behavioural MDU: RISC-V M semantics
  function automatic logic [31:0] mdu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    case (op)
      3'd0: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
      3'd1: begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return ps[63:32]; end
      3'd2: begin ps = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return ps[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'($signed(a) / $signed(b));
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  logic mul_q = 1'b0, mul_prev_q = 1'b0, div_done_q = 1'b0;
  int   div_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      mul_q      <= 1'b0;
      mul_prev_q <= 1'b0;
      div_cnt    <= 0;
      div_done_q <= 1'b0;
    end else begin
      mul_q      <= mdu_valid && !mdu_op[2];
      mul_prev_q <= mul_q;
      if (!mdu_valid) div_done_q <= 1'b0;
      if (div_cnt == 1) div_done_q <= 1'b1;
      if (div_cnt != 0) div_cnt <= div_cnt - 1;
      else if (mdu_valid && mdu_op[2] && !div_done_q) div_cnt <= 34;
    end
  end

  assign mdu_ready = mul_q || (div_cnt == 1);
  // Second consecutive mul strobe is the trailing one; give it a poison value.
  assign mdu_rd = (mul_q && mul_prev_q) ? 32'hDEAD_BEEF : mdu_fn(mdu_op, mdu_rs1, mdu_rs2);

  // Requester drivers: present queue head, pop when accepted
  logic acc0 = 1'b0, acc1 = 1'b0;
  always @(negedge clk) begin
    acc0 = req0_valid && req0_ready && !rst;
    acc1 = req1_valid && req1_ready && !rst;
  end

  always @(posedge clk) begin
    #1;
    if (acc0 && q0.size() > 0) void'(q0.pop_front());
    if (q0.size() > 0) begin
      req0_valid = 1'b1; req0_rs1 = q0[0].rs1; req0_rs2 = q0[0].rs2; req0_op = q0[0].op;
    end else req0_valid = 1'b0;
    if (acc1 && q1.size() > 0) void'(q1.pop_front());
    if (q1.size() > 0) begin
      req1_valid = 1'b1; req1_rs1 = q1[0].rs1; req1_rs2 = q1[0].rs2; req1_op = q1[0].op;
    end else req1_valid = 1'b0;
  end

  // Monitor: grants, responses and stability against the scoreboard queues
  logic        p_mv = 1'b0, p_r0v = 1'b0, p_r1v = 1'b0, p_r0r = 1'b0, p_r1r = 1'b0;
  logic [31:0] p_rs1 = '0, p_rs2 = '0, p_rd = '0;
  logic [2:0]  p_op = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (req0_ready || req1_ready) begin
        chk("ready_onehot", 32'(req0_ready & req1_ready), 32'd0);
        if (exp_gnt.size() == 0) timeout("unexpected_grant");
        else chk("grant", 32'(req1_ready), 32'(exp_gnt.pop_front()));
      end
      if (rsp0_valid || rsp1_valid) chk("rsp_onehot", 32'(rsp0_valid & rsp1_valid), 32'd0);
      if (rsp0_valid && rsp0_ready) begin
        if (exp_rsp0.size() == 0) timeout("unexpected_rsp0");
        else chk("rsp0_data", rsp_rd, exp_rsp0.pop_front());
      end
      if (rsp1_valid && rsp1_ready) begin
        if (exp_rsp1.size() == 0) timeout("unexpected_rsp1");
        else chk("rsp1_data", rsp_rd, exp_rsp1.pop_front());
      end
      if (p_mv && mdu_valid) begin
        chk("mdu_rs1_stable", mdu_rs1, p_rs1);
        chk("mdu_rs2_stable", mdu_rs2, p_rs2);
        chk("mdu_op_stable", 32'(mdu_op), 32'(p_op));
      end
      if ((p_r0v && !p_r0r) || (p_r1v && !p_r1r)) begin
        chk("rsp_valid_held", {30'b0, rsp1_valid, rsp0_valid}, {30'b0, p_r1v, p_r0v});
        chk("rsp_rd_held", rsp_rd, p_rd);
      end
    end
    p_mv = mdu_valid && !rst; p_rs1 = mdu_rs1; p_rs2 = mdu_rs2; p_op = mdu_op;
    p_r0v = rsp0_valid && !rst; p_r1v = rsp1_valid && !rst;
    p_r0r = rsp0_ready; p_r1r = rsp1_ready; p_rd = rsp_rd;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic sel(input int which);
    case (which)
      0: return req0_ready;
      1: return req1_ready;
      2: return rsp0_valid;
      default: return rsp1_valid;
    endcase
  endfunction

  task automatic wait_for(input int which, input int max, input string name);
    for (int i = 0; i < max; i++) begin
      step();
      if (sel(which)) return;
    end
    timeout(name);
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      step();
      if (!busy && q0.size() == 0 && q1.size() == 0 && exp_rsp0.size() == 0 && exp_rsp1.size() == 0) return;
    end
    timeout("idle");
  endtask

  function automatic req_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    req_t r;
    r.rs1 = a; r.rs2 = b; r.op = op;
    return r;
  endfunction

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mdu_valid", 32'(mdu_valid), 32'd0);
    chk("rst_rsp_valid", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_req_ready", {30'b0, req1_ready, req0_ready}, 32'd0);
    chk("rst_rsp_rd", rsp_rd, 32'd0);
    chk("rst_mdu_ops", mdu_rs1 | mdu_rs2 | 32'(mdu_op), 32'd0);
    rst = 1'b0;
    step();

    // MUL 6x7 alone, cycle-accurate timing
    exp_gnt.push_back(0); exp_rsp0.push_back(32'd42);
    q0.push_back(mk(32'd6, 32'd7, 3'd0));
    wait_for(0, 10, "t1_accept");
    chk("t1_T_mdu_valid", 32'(mdu_valid), 32'd0);
    step();
    chk("t1_T1_mdu_valid", 32'(mdu_valid), 32'd1);
    chk("t1_T1_busy", 32'(busy), 32'd1);
    chk("t1_T1_rs1", mdu_rs1, 32'd6);
    chk("t1_T1_rs2", mdu_rs2, 32'd7);
    chk("t1_T1_op", 32'(mdu_op), 32'd0);
    step();
    chk("t1_T2_mdu_valid", 32'(mdu_valid), 32'd1);
    chk("t1_T2_rsp0_valid", 32'(rsp0_valid), 32'd0);
    step();
    chk("t1_T3_rsp0_valid", 32'(rsp0_valid), 32'd1);
    chk("t1_T3_rsp_rd", rsp_rd, 32'd42);
    chk("t1_T3_mdu_valid", 32'(mdu_valid), 32'd0);
    step();
    chk("t1_T4_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("t1_T4_busy", 32'(busy), 32'd0);
    chk("t1_T4_rsp_rd_kept", rsp_rd, 32'd42);
    wait_idle(20);

    // DIV -7/2 from requester 1
    exp_gnt.push_back(1); exp_rsp1.push_back(32'hFFFF_FFFD);
    q1.push_back(mk(32'hFFFF_FFF9, 32'd2, 3'd4));
    wait_for(1, 10, "t2_accept");
    for (int i = 0; i < 60 && !rsp1_valid; i++) begin
      step();
      chk("t2_rsp0_quiet", 32'(rsp0_valid), 32'd0);
    end
    chk("t2_rsp1_valid", 32'(rsp1_valid), 32'd1);
    chk("t2_rsp_rd", rsp_rd, 32'hFFFF_FFFD);
    wait_idle(20);

    // Both valid continuously: MUL 3x5 vs REMU 17%5
`ifdef MDU_ARB_FIXED_PRIO_EN
    exp_gnt.push_back(0); exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(1);
`else
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(0); exp_gnt.push_back(1);
`endif
    repeat (2) begin
      exp_rsp0.push_back(32'd15); exp_rsp1.push_back(32'd2);
      q0.push_back(mk(32'd3, 32'd5, 3'd0));
      q1.push_back(mk(32'd17, 32'd5, 3'd7));
    end
    wait_idle(300);

    // MULHU with response backpressure; queued req1 must wait
    rsp0_ready = 1'b0;
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    exp_rsp0.push_back(32'hFFFF_FFFE); exp_rsp1.push_back(32'd1);
    q0.push_back(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd3));
    q1.push_back(mk(32'd1, 32'd1, 3'd0));
    wait_for(0, 10, "t4_accept");
    wait_for(2, 10, "t4_rsp0_valid");
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", 32'(rsp0_valid), 32'd1);
      chk("t4_hold_rd", rsp_rd, 32'hFFFF_FFFE);
      chk("t4_no_accept", 32'(req1_ready), 32'd0);
      step();
    end
    @(posedge clk);
    #1 rsp0_ready = 1'b1;
    wait_idle(30);

    // Reset 10 cycles into a DIV: no response, then normal traffic
    exp_gnt.push_back(0);
    q0.push_back(mk(32'd100, 32'd3, 3'd4));
    wait_for(0, 10, "t5_accept");
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_busy_after_rst", 32'(busy), 32'd0);
    for (int i = 0; i < 40; i++) begin
      step();
      chk("t5_no_rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
    end
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    exp_rsp0.push_back(32'd4); exp_rsp1.push_back(32'd1);
    q0.push_back(mk(32'd2, 32'd2, 3'd0));
    q1.push_back(mk(32'd1, 32'd1, 3'd0));
    wait_idle(30);

    // Both valid for three ops each
`ifdef MDU_ARB_FIXED_PRIO_EN
    repeat (3) exp_gnt.push_back(0);
    repeat (3) exp_gnt.push_back(1);
`else
    repeat (3) begin exp_gnt.push_back(0); exp_gnt.push_back(1); end
`endif
    repeat (3) begin
      exp_rsp0.push_back(32'd15); exp_rsp1.push_back(32'd2);
      q0.push_back(mk(32'd3, 32'd5, 3'd0));
      q1.push_back(mk(32'd17, 32'd5, 3'd7));
    end
    wait_idle(400);

    repeat (5) step();
    chk("end_grants_left", 32'(exp_gnt.size()), 32'd0);
    chk("end_rsp_left", 32'(exp_rsp0.size() + exp_rsp1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
